// File: rtl/seq_det_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// seq_det_ctrl_pkg
//   Shared encodings for the word-level 1101 detector controller.
//   det_state_t  : bit-serial detector states (S0 none, S1 "1", S2 "11", S3 "110")
//   ctrl_state_t : handshake controller states (IDLE, SHIFT, REPORT)
// -----------------------------------------------------------------------------
package seq_det_ctrl_pkg;

  typedef enum logic [1:0] {
    DET_S0 = 2'd0,
    DET_S1 = 2'd1,
    DET_S2 = 2'd2,
    DET_S3 = 2'd3
  } det_state_t;

  typedef enum logic [1:0] {
    CTRL_IDLE   = 2'd0,
    CTRL_SHIFT  = 2'd1,
    CTRL_REPORT = 2'd2
  } ctrl_state_t;

endpackage

// File: rtl/seq_det_ctrl_if.sv
// -----------------------------------------------------------------------------
// seq_det_ctrl_if
//   Word input channel and result output channel of seq_det_ctrl.
//   in_valid/in_ready/in_data    : word source -> controller (in_data MSB first)
//   out_valid/out_ready          : controller -> result consumer
//   out_count/out_hit            : per-word match count and (count != 0)
//   master modport: word source / result consumer side
//   slave  modport: controller side
// -----------------------------------------------------------------------------
interface seq_det_ctrl_if #(
  parameter int W     = 8,
  parameter int CNT_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_data;
  logic             out_valid;
  logic             out_ready;
  logic [CNT_W-1:0] out_count;
  logic             out_hit;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_count, out_hit
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_count, out_hit
  );
endinterface

// File: rtl/seq_det_ctrl_core.sv
// -----------------------------------------------------------------------------
// seq_det_core
//   Bit-serial Mealy detector for the pattern 1101, overlapping matches allowed.
//   Ports:
//     clk    in  clock, rising edge
//     reset  in  asynchronous, active-high; state -> S0
//     i_en   in  advance the detector by one bit
//     i_clr  in  force state to S0 on the next edge (has priority over i_en)
//     i_x    in  serial input bit
//     o_z    out combinational match flag (state S3 and i_x = 1)
// -----------------------------------------------------------------------------
module seq_det_core
  import seq_det_ctrl_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic i_en,
  input  logic i_clr,
  input  logic i_x,
  output logic o_z
);

  det_state_t r_state;
  det_state_t w_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)      r_state <= DET_S0;
    else if (i_clr) r_state <= DET_S0;
    else if (i_en)  r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    o_z    = 1'b0;
    case (r_state)
      DET_S0: w_next = i_x ? DET_S1 : DET_S0;
      DET_S1: w_next = i_x ? DET_S2 : DET_S0;
      DET_S2: w_next = i_x ? DET_S2 : DET_S3;
      DET_S3: begin
        // A completed 1101 leaves a trailing "1", so the overlap restarts in S1.
        w_next = i_x ? DET_S1 : DET_S0;
        o_z    = i_x;
      end
      default: w_next = DET_S0;
    endcase
  end

endmodule

// File: rtl/seq_det_ctrl.sv
// -----------------------------------------------------------------------------
// seq_det_ctrl
//   Word-level controller for the serial 1101 detector. Accepts a word over a
//   valid/ready channel, shifts it MSB-first through seq_det_core for W cycles,
//   then reports the per-word match count over a valid/ready channel and adds it
//   to a saturating running total.
//   Ports:
//     clk            in   clock, rising edge
//     reset          in   asynchronous, active-high
//     bus            slave modport of seq_det_ctrl_if (word in / result out)
//     i_clr_total    in   synchronous clear of the running total (wins over add)
//     o_total_count  out  saturating sum of all reported counts
//     o_busy         out  controller not in IDLE
//   Configuration macro:
//     SEQ_CLEAR_ON_WORD_EN  defined -> detector cleared on every word load, so
//                           matches never straddle words; undefined -> detector
//                           state carries across words.
// -----------------------------------------------------------------------------
module seq_det_ctrl
  import seq_det_ctrl_pkg::*;
#(
  parameter int W       = 8,
  parameter int CNT_W   = 4,
  parameter int TOTAL_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  seq_det_ctrl_if.slave      bus,
  input  logic               i_clr_total,
  output logic [TOTAL_W-1:0] o_total_count,
  output logic               o_busy
);

  localparam int IDX_W = (W > 1) ? $clog2(W) : 1;

  ctrl_state_t      r_state;
  ctrl_state_t      w_next;
  logic [W-1:0]     r_shift;
  logic [IDX_W-1:0] r_bit_idx;
  logic [CNT_W-1:0] r_count;
  logic [TOTAL_W-1:0] r_total;

  logic w_load;
  logic w_shift_en;
  logic w_handshake;
  logic w_det_clr;
  logic w_z;

  function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic logic [TOTAL_W-1:0] sat_add_total(input logic [TOTAL_W-1:0] t,
                                                       input logic [CNT_W-1:0]   c);
    logic [TOTAL_W:0] sum;
    sum = {1'b0, t} + (TOTAL_W+1)'(c);
    return sum[TOTAL_W] ? {TOTAL_W{1'b1}} : sum[TOTAL_W-1:0];
  endfunction

`ifdef SEQ_CLEAR_ON_WORD_EN
  assign w_det_clr = w_load;
`else
  assign w_det_clr = 1'b0;
`endif

  seq_det_core u_core (
    .clk   (clk),
    .reset (reset),
    .i_en  (w_shift_en),
    .i_clr (w_det_clr),
    .i_x   (r_shift[W-1]),
    .o_z   (w_z)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= CTRL_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next        = r_state;
    w_load        = 1'b0;
    w_shift_en    = 1'b0;
    w_handshake   = 1'b0;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    case (r_state)
      CTRL_IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          w_load = 1'b1;
          w_next = CTRL_SHIFT;
        end
      end
      CTRL_SHIFT: begin
        w_shift_en = 1'b1;
        if (r_bit_idx == '0) w_next = CTRL_REPORT;
      end
      CTRL_REPORT: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) begin
          w_handshake = 1'b1;
          w_next      = CTRL_IDLE;
        end
      end
      default: w_next = CTRL_IDLE;
    endcase
  end

  // Shifter, bit index and per-word count; count captures the Mealy output in SHIFT.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_shift   <= '0;
      r_bit_idx <= '0;
      r_count   <= '0;
    end else if (w_load) begin
      r_shift   <= bus.in_data;
      r_bit_idx <= IDX_W'(W-1);
      r_count   <= '0;
    end else if (w_shift_en) begin
      r_shift <= r_shift << 1;
      if (r_bit_idx != '0) r_bit_idx <= r_bit_idx - 1'b1;
      if (w_z)             r_count   <= sat_inc_cnt(r_count);
    end
  end

  // Running total: a coincident clear discards the word being reported.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)            r_total <= '0;
    else if (i_clr_total) r_total <= '0;
    else if (w_handshake) r_total <= sat_add_total(r_total, r_count);
  end

  assign bus.out_count = r_count;
  assign bus.out_hit   = |r_count;
  assign o_total_count = r_total;
  assign o_busy        = (r_state != CTRL_IDLE);

endmodule

// File: tb/tb_seq_det_ctrl.sv
// -----------------------------------------------------------------------------
// tb_seq_det_ctrl
//   Self-checking bench for seq_det_ctrl. Two instances run in lockstep on the
//   same stimulus: u_dut (TOTAL_W=16) and u_dut4 (TOTAL_W=4, for total
//   saturation). Expected per-word counts come from a window-matching model of
//   the serial stream and are queued when a word is driven, popped at the result.
// -----------------------------------------------------------------------------
module tb_seq_det_ctrl;

  logic clk = 1'b0;
  logic reset;
  logic clr_total;
  logic [15:0] total16;
  logic [3:0]  total4;
  logic busy, busy4;

  always #5 clk = ~clk;

  seq_det_ctrl_if #(.W(8), .CNT_W(4)) bif ();
  seq_det_ctrl_if #(.W(8), .CNT_W(4)) bif4 ();

  assign bif4.in_valid  = bif.in_valid;
  assign bif4.in_data   = bif.in_data;
  assign bif4.out_ready = bif.out_ready;

  seq_det_ctrl #(.W(8), .CNT_W(4), .TOTAL_W(16)) u_dut (
    .clk           (clk),
    .reset         (reset),
    .bus           (bif.slave),
    .i_clr_total   (clr_total),
    .o_total_count (total16),
    .o_busy        (busy)
  );

  seq_det_ctrl #(.W(8), .CNT_W(4), .TOTAL_W(4)) u_dut4 (
    .clk           (clk),
    .reset         (reset),
    .bus           (bif4.slave),
    .i_clr_total   (clr_total),
    .o_total_count (total4),
    .o_busy        (busy4)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: tail of the last three stream bits and how many are valid.
  logic [2:0] m_tail;
  int         m_len;
  int         m_tot16;
  int         m_tot4;
  int         exp_q[$];

  function automatic int model_word(input logic [7:0] d);
    int c = 0;
`ifdef SEQ_CLEAR_ON_WORD_EN
    m_len = 0;
`endif
    for (int i = 7; i >= 0; i--) begin
      if (m_len >= 3 && {m_tail, d[i]} == 4'b1101) c++;
      m_tail = {m_tail[1:0], d[i]};
      if (m_len < 3) m_len++;
    end
    return (c > 15) ? 15 : c;
  endfunction

  task automatic model_reset();
    m_tail  = 3'b000;
    m_len   = 0;
    m_tot16 = 0;
    m_tot4  = 0;
    exp_q.delete();
  endtask

  task automatic send_word(input logic [7:0] d, output bit to);
    int n = 0;
    to = 1'b0;
    while (bif.in_ready !== 1'b1 && n < 40) begin
      @(posedge clk); #1; n++;
    end
    if (bif.in_ready !== 1'b1) begin
      to = 1'b1;
      return;
    end
    bif.in_valid = 1'b1;
    bif.in_data  = d;
    exp_q.push_back(model_word(d));
    @(posedge clk); #1;
    bif.in_valid = 1'b0;
  endtask

  // lat counts edges from the accept edge (inclusive) to out_valid.
  task automatic wait_out(output int lat, output bit to);
    lat = 1;
    while (bif.out_valid !== 1'b1 && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
    to = (bif.out_valid !== 1'b1);
  endtask

  task automatic ack(input int e, input bit clr);
    bif.out_ready = 1'b1;
    clr_total     = clr;
    @(posedge clk); #1;
    bif.out_ready = 1'b0;
    clr_total     = 1'b0;
    if (clr) begin
      m_tot16 = 0;
      m_tot4  = 0;
    end else begin
      m_tot16 = (m_tot16 + e > 65535) ? 65535 : m_tot16 + e;
      m_tot4  = (m_tot4 + e > 15) ? 15 : m_tot4 + e;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk); #1;
    model_reset();
    n_cmp++; if (bif.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=1", bif.in_ready); end
    n_cmp++; if (bif.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", bif.out_valid); end
    n_cmp++; if (bif.out_hit !== 1'b0) begin n_fail++; $display("FAIL reset_out_hit got=%b exp=0", bif.out_hit); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_cmp++; if (bif.out_count !== 4'd0) begin n_fail++; $display("FAIL reset_out_count got=%0d exp=0", bif.out_count); end
    n_cmp++; if (total16 !== 16'd0) begin n_fail++; $display("FAIL reset_total got=%0d exp=0", total16); end
  endtask

  task automatic test_single();
    bit to; int lat; int e;
    send_word(8'b1101_0000, to);
    n_cmp++; if (to) begin n_fail++; $display("FAIL single_accept got=timeout exp=accepted"); return; end
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy got=%b exp=1", busy); end
    wait_out(lat, to);
    n_cmp++; if (to) begin n_fail++; $display("FAIL single_out got=timeout exp=out_valid"); return; end
    e = exp_q.pop_front();
    n_cmp++; if (lat !== 9) begin n_fail++; $display("FAIL single_latency got=%0d exp=9", lat); end
    n_cmp++; if (bif.out_count !== 4'(e) || bif.out_count !== 4'd1) begin n_fail++; $display("FAIL single_count got=%0d exp=1", bif.out_count); end
    n_cmp++; if (bif.out_hit !== 1'b1) begin n_fail++; $display("FAIL single_hit got=%b exp=1", bif.out_hit); end
    ack(e, 1'b0);
    n_cmp++; if (total16 !== 16'd1) begin n_fail++; $display("FAIL single_total got=%0d exp=1", total16); end
  endtask

  task automatic test_overlap();
    bit to; int lat; int e;
    send_word(8'b1101_1010, to);
    wait_out(lat, to);
    n_cmp++; if (to) begin n_fail++; $display("FAIL overlap_out got=timeout exp=out_valid"); return; end
    e = exp_q.pop_front();
    n_cmp++; if (bif.out_count !== 4'(e) || bif.out_count !== 4'd2) begin n_fail++; $display("FAIL overlap_count got=%0d exp=2", bif.out_count); end
    ack(e, 1'b0);
    n_cmp++; if (total16 !== 16'(m_tot16) || total16 !== 16'd3) begin n_fail++; $display("FAIL overlap_total got=%0d exp=3", total16); end
  endtask

  task automatic test_cross_word();
    bit to; int lat; int e; logic [3:0] want;
`ifdef SEQ_CLEAR_ON_WORD_EN
    want = 4'd0;
`else
    want = 4'd1;
`endif
    send_word(8'b0000_0110, to);
    wait_out(lat, to);
    n_cmp++; if (to) begin n_fail++; $display("FAIL cross_first got=timeout exp=out_valid"); return; end
    e = exp_q.pop_front();
    n_cmp++; if (bif.out_count !== 4'(e)) begin n_fail++; $display("FAIL cross_first_count got=%0d exp=%0d", bif.out_count, e); end
    ack(e, 1'b0);
    send_word(8'b1000_0000, to);
    wait_out(lat, to);
    n_cmp++; if (to) begin n_fail++; $display("FAIL cross_second got=timeout exp=out_valid"); return; end
    e = exp_q.pop_front();
    n_cmp++; if (bif.out_count !== 4'(e) || bif.out_count !== want) begin n_fail++; $display("FAIL cross_second_count got=%0d exp=%0d", bif.out_count, want); end
    n_cmp++; if (bif.out_hit !== (want != 0)) begin n_fail++; $display("FAIL cross_second_hit got=%b exp=%b", bif.out_hit, want != 0); end
    ack(e, 1'b0);
    n_cmp++; if (total16 !== 16'(m_tot16)) begin n_fail++; $display("FAIL cross_total got=%0d exp=%0d", total16, m_tot16); end
  endtask

  task automatic test_stall();
    bit to; int lat; int e; logic [15:0] tot_before;
    send_word(8'b1101_0000, to);
    wait_out(lat, to);
    n_cmp++; if (to) begin n_fail++; $display("FAIL stall_out got=timeout exp=out_valid"); return; end
    e = exp_q.pop_front();
    tot_before = total16;
    // A word offered during REPORT must be ignored.
    bif.in_valid = 1'b1;
    bif.in_data  = 8'b1101_1101;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      n_cmp++; if (bif.out_valid !== 1'b1) begin n_fail++; $display("FAIL stall_valid[%0d] got=%b exp=1", k, bif.out_valid); end
      n_cmp++; if (bif.out_count !== 4'(e)) begin n_fail++; $display("FAIL stall_count[%0d] got=%0d exp=%0d", k, bif.out_count, e); end
      n_cmp++; if (bif.in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready[%0d] got=%b exp=0", k, bif.in_ready); end
      n_cmp++; if (total16 !== tot_before) begin n_fail++; $display("FAIL stall_total[%0d] got=%0d exp=%0d", k, total16, tot_before); end
      n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL stall_busy[%0d] got=%b exp=1", k, busy); end
    end
    bif.in_valid = 1'b0;
    ack(e, 1'b0);
    n_cmp++; if (total16 !== 16'(m_tot16)) begin n_fail++; $display("FAIL stall_total_after got=%0d exp=%0d", total16, m_tot16); end
    n_cmp++; if (busy !== 1'b0 || bif.out_valid !== 1'b0) begin n_fail++; $display("FAIL stall_idle got=busy%b/valid%b exp=0/0", busy, bif.out_valid); end
  endtask

  task automatic test_saturate();
    bit to; int lat; int e;
    for (int k = 0; k < 8; k++) begin
      send_word(8'b1101_1010, to);
      wait_out(lat, to);
      n_cmp++; if (to) begin n_fail++; $display("FAIL sat_out[%0d] got=timeout exp=out_valid", k); return; end
      e = exp_q.pop_front();
      n_cmp++; if (bif.out_count !== 4'(e)) begin n_fail++; $display("FAIL sat_count[%0d] got=%0d exp=%0d", k, bif.out_count, e); end
      ack(e, 1'b0);
    end
    n_cmp++; if (total4 !== 4'd15) begin n_fail++; $display("FAIL sat_total4 got=%0d exp=15", total4); end
    n_cmp++; if (total16 !== 16'(m_tot16)) begin n_fail++; $display("FAIL sat_total16 got=%0d exp=%0d", total16, m_tot16); end
    // Clear coinciding with the handshake: clear wins, the word is not added.
    send_word(8'b1101_0000, to);
    wait_out(lat, to);
    n_cmp++; if (to) begin n_fail++; $display("FAIL clr_out got=timeout exp=out_valid"); return; end
    e = exp_q.pop_front();
    ack(e, 1'b1);
    n_cmp++; if (total16 !== 16'd0) begin n_fail++; $display("FAIL clr_total16 got=%0d exp=0", total16); end
    n_cmp++; if (total4 !== 4'd0) begin n_fail++; $display("FAIL clr_total4 got=%0d exp=0", total4); end
  endtask

  task automatic test_reset_mid();
    bit to; int lat; int e;
    send_word(8'b1111_1111, to);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    n_cmp++; if (bif.in_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_in_ready got=%b exp=1", bif.in_ready); end
    n_cmp++; if (bif.out_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_out_valid got=%b exp=0", bif.out_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rmid_busy got=%b exp=0", busy); end
    n_cmp++; if (bif.out_count !== 4'd0 || total16 !== 16'd0) begin n_fail++; $display("FAIL rmid_counts got=%0d/%0d exp=0/0", bif.out_count, total16); end
    send_word(8'b1101_0000, to);
    wait_out(lat, to);
    n_cmp++; if (to) begin n_fail++; $display("FAIL rmid_out got=timeout exp=out_valid"); return; end
    e = exp_q.pop_front();
    n_cmp++; if (bif.out_count !== 4'(e) || bif.out_count !== 4'd1) begin n_fail++; $display("FAIL rmid_count got=%0d exp=1", bif.out_count); end
    ack(e, 1'b0);
    n_cmp++; if (total16 !== 16'd1) begin n_fail++; $display("FAIL rmid_total got=%0d exp=1", total16); end
  endtask

  task automatic test_back_to_back();
    bit to; int lat; int e; logic [7:0] d;
    for (int k = 0; k < 10; k++) begin
      d = 8'($urandom_range(0, 255));
      send_word(d, to);
      wait_out(lat, to);
      n_cmp++; if (to) begin n_fail++; $display("FAIL b2b_out[%0d] got=timeout exp=out_valid", k); return; end
      e = exp_q.pop_front();
      n_cmp++; if (bif.out_count !== 4'(e)) begin n_fail++; $display("FAIL b2b_count[%0d] data=%b got=%0d exp=%0d", k, d, bif.out_count, e); end
      n_cmp++; if (bif.out_hit !== (e != 0)) begin n_fail++; $display("FAIL b2b_hit[%0d] got=%b exp=%b", k, bif.out_hit, e != 0); end
      ack(e, 1'b0);
      n_cmp++; if (total16 !== 16'(m_tot16) || total4 !== 4'(m_tot4)) begin n_fail++; $display("FAIL b2b_total[%0d] got=%0d/%0d exp=%0d/%0d", k, total16, total4, m_tot16, m_tot4); end
    end
  endtask

  initial begin
    reset         = 1'b1;
    clr_total     = 1'b0;
    bif.in_valid  = 1'b0;
    bif.in_data   = 8'h00;
    bif.out_ready = 1'b0;
    model_reset();
    test_reset();
    test_single();
    test_overlap();
    test_cross_word();
    test_stall();
    test_saturate();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=bench completion");
    $fatal(1, "watchdog expired");
  end

endmodule
